// File: rtl/run_code_delay_pipe.sv
// run_code_delay_pipe
//
// Purpose: multi-stage delay line for the run-mode encoder path. Two
// independent channels (run code bits/length, and Golomb k/glimit/mapped
// error) are delayed by DEPTH advancing cycles so they line up with the
// regular-mode path feeding the bit packer and Golomb coder. A global stall
// freezes everything, a synchronous flush drops all in-flight entries,
// per-channel counters report occupancy, and len_err latches any accepted
// code length wider than CW.
//
// Configuration macro: RUNPIPE_ZERO_INVALID_EN
//   defined   - invalid stages carry all-zero data and flush zeroes data,
//               so data outputs read 0 whenever their valid is 0.
//   undefined - only valid bits are gated; data outputs are don't-care
//               while the matching valid is 0.
//
// Ports:
//   clk, reset (async, active-high), stall, flush
//   en_out1_in, codes_r_in[CW], codes_r_len_in[LW]        channel 1 in
//   en_out2_in, k_in[KW], glimit_in[GW], EMErrval_in[EW]  channel 2 in
//   en_out1_out, codes_r_out, codes_r_len_out             channel 1 out
//   en_out2_out, k_out, glimit_out, EMErrval_out          channel 2 out
//   cnt1, cnt2 [NW]  valid entries held per channel
//   idle             both counters zero
//   len_err          sticky: accepted channel-1 length > CW
module run_code_delay_pipe #(
   parameter int DEPTH = 2,
   parameter int CW    = 32,
   parameter int LW    = 6,
   parameter int KW    = 5,
   parameter int GW    = 6,
   parameter int EW    = 9,
   parameter int NW    = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          stall,
   input  logic          flush,
   input  logic          en_out1_in,
   input  logic [CW-1:0] codes_r_in,
   input  logic [LW-1:0] codes_r_len_in,
   input  logic          en_out2_in,
   input  logic [KW-1:0] k_in,
   input  logic [GW-1:0] glimit_in,
   input  logic [EW-1:0] EMErrval_in,
   output logic          en_out1_out,
   output logic [CW-1:0] codes_r_out,
   output logic [LW-1:0] codes_r_len_out,
   output logic          en_out2_out,
   output logic [KW-1:0] k_out,
   output logic [GW-1:0] glimit_out,
   output logic [EW-1:0] EMErrval_out,
   output logic [NW-1:0] cnt1,
   output logic [NW-1:0] cnt2,
   output logic          idle,
   output logic          len_err
);

   localparam logic [31:0] CW_LIM = CW;

   // Occupancy update: +1 on entry only, -1 on exit only, else unchanged.
   function automatic logic [NW-1:0] cnt_next(input logic [NW-1:0] cnt,
                                              input logic in_v,
                                              input logic out_v);
      logic [NW-1:0] one;
      one = {{(NW-1){1'b0}}, 1'b1};
      case ({in_v, out_v})
         2'b10:   cnt_next = cnt + one;
         2'b01:   cnt_next = cnt - one;
         default: cnt_next = cnt;
      endcase
   endfunction

   function automatic logic len_too_long(input logic [LW-1:0] len);
      logic [31:0] len32;
      len32 = 32'(len);
      len_too_long = (len32 > CW_LIM);
   endfunction

   // Stage storage, index 0 = input side, DEPTH-1 = output side
   logic          v1_q    [DEPTH];
   logic [CW-1:0] code_q  [DEPTH];
   logic [LW-1:0] len_q   [DEPTH];
   logic          v2_q    [DEPTH];
   logic [KW-1:0] k_q     [DEPTH];
   logic [GW-1:0] glim_q  [DEPTH];
   logic [EW-1:0] err_q   [DEPTH];

   logic [NW-1:0] cnt1_q, cnt1_d;
   logic [NW-1:0] cnt2_q, cnt2_d;
   logic          len_err_q, len_err_d;

   // Stage-0 load values (zero-gated when the macro is enabled)
   logic [CW-1:0] code0_d;
   logic [LW-1:0] len0_d;
   logic [KW-1:0] k0_d;
   logic [GW-1:0] glim0_d;
   logic [EW-1:0] err0_d;

   always_comb begin
      cnt1_d    = cnt_next(cnt1_q, en_out1_in, v1_q[DEPTH-1]);
      cnt2_d    = cnt_next(cnt2_q, en_out2_in, v2_q[DEPTH-1]);
      len_err_d = len_err_q | (en_out1_in & len_too_long(codes_r_len_in));
`ifdef RUNPIPE_ZERO_INVALID_EN
      code0_d = en_out1_in ? codes_r_in     : '0;
      len0_d  = en_out1_in ? codes_r_len_in : '0;
      k0_d    = en_out2_in ? k_in           : '0;
      glim0_d = en_out2_in ? glimit_in      : '0;
      err0_d  = en_out2_in ? EMErrval_in    : '0;
`else
      code0_d = codes_r_in;
      len0_d  = codes_r_len_in;
      k0_d    = k_in;
      glim0_d = glimit_in;
      err0_d  = EMErrval_in;
`endif
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            v1_q[i]   <= 1'b0;
            code_q[i] <= '0;
            len_q[i]  <= '0;
            v2_q[i]   <= 1'b0;
            k_q[i]    <= '0;
            glim_q[i] <= '0;
            err_q[i]  <= '0;
         end
         cnt1_q    <= '0;
         cnt2_q    <= '0;
         len_err_q <= 1'b0;
      end else if (flush) begin
         // Flush wins over stall; len_err deliberately survives it.
         for (int i = 0; i < DEPTH; i++) begin
            v1_q[i] <= 1'b0;
            v2_q[i] <= 1'b0;
`ifdef RUNPIPE_ZERO_INVALID_EN
            code_q[i] <= '0;
            len_q[i]  <= '0;
            k_q[i]    <= '0;
            glim_q[i] <= '0;
            err_q[i]  <= '0;
`endif
         end
         cnt1_q <= '0;
         cnt2_q <= '0;
      end else if (!stall) begin
         // ---- stage 0: sample inputs ----
         v1_q[0]   <= en_out1_in;
         code_q[0] <= code0_d;
         len_q[0]  <= len0_d;
         v2_q[0]   <= en_out2_in;
         k_q[0]    <= k0_d;
         glim_q[0] <= glim0_d;
         err_q[0]  <= err0_d;
         // ---- stages 1..DEPTH-1: shift ----
         // Invalid entries upstream already carry zero data when gating is on,
         // so a plain copy keeps the zero-data property.
         for (int i = 1; i < DEPTH; i++) begin
            v1_q[i]   <= v1_q[i-1];
            code_q[i] <= code_q[i-1];
            len_q[i]  <= len_q[i-1];
            v2_q[i]   <= v2_q[i-1];
            k_q[i]    <= k_q[i-1];
            glim_q[i] <= glim_q[i-1];
            err_q[i]  <= err_q[i-1];
         end
         cnt1_q    <= cnt1_d;
         cnt2_q    <= cnt2_d;
         len_err_q <= len_err_d;
      end
   end

   // ---- output: last stage drives ports directly ----
   assign en_out1_out     = v1_q[DEPTH-1];
   assign codes_r_out     = code_q[DEPTH-1];
   assign codes_r_len_out = len_q[DEPTH-1];
   assign en_out2_out     = v2_q[DEPTH-1];
   assign k_out           = k_q[DEPTH-1];
   assign glimit_out      = glim_q[DEPTH-1];
   assign EMErrval_out    = err_q[DEPTH-1];
   assign cnt1            = cnt1_q;
   assign cnt2            = cnt2_q;
   assign idle            = (cnt1_q == '0) && (cnt2_q == '0);
   assign len_err         = len_err_q;

endmodule
